// File: rtl/alu_ctrl_pkg.sv
// Shared constants for the shared-adder arbiter: flag bit positions and default widths.
package alu_ctrl_pkg;

    localparam int FLAG_SIGN   = 0;
    localparam int FLAG_ZERO   = 1;
    localparam int FLAG_CARRY  = 2;
    localparam int FLAG_PARITY = 3;
    localparam int FLAG_OVF    = 4;

    localparam int FLAGS_W = 5;
    localparam int DATA_W  = 16;

    typedef logic [FLAGS_W-1:0] flags_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first asserted request after 'pointer', wrapping around.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    pointer,
    input  logic               enable,
    output logic [NUM_REQ-1:0] gnt,
    output logic [ID_W-1:0]    gnt_idx
);

    logic            found;
    logic [ID_W-1:0] idx;

    // Scan NUM_REQ positions starting just past the last winner; the first hit wins.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = ID_W'((int'(pointer) + i) % NUM_REQ);
            if (enable && !found && req[idx]) begin
                gnt[idx] = 1'b1;
                gnt_idx  = idx;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one adder/flag datapath among NUM_REQ requesters through a round-robin
// grant and a two-stage pipeline (operand register, then result register).
module alu_share_arbiter
    import alu_ctrl_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = DATA_W,
    parameter int ID_W    = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*WIDTH-1:0] x_in,
    input  logic [NUM_REQ*WIDTH-1:0] y_in,
    output logic [NUM_REQ-1:0]       gnt,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [ID_W-1:0]          rsp_id,
    output logic [WIDTH-1:0]         z,
    output logic [FLAGS_W-1:0]       flags
);

    logic             stall;
    logic             grant_any;
    logic [ID_W-1:0]  gnt_idx;
    logic [WIDTH:0]   sum;
    flags_t           alu_flags;

    logic [ID_W-1:0]  ptr_q, ptr_d;
    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] s1_x_q, s1_x_d;
    logic [WIDTH-1:0] s1_y_q, s1_y_d;
    logic [ID_W-1:0]  s1_id_q, s1_id_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0] z_q, z_d;
    flags_t           flags_q, flags_d;
    logic [ID_W-1:0]  rsp_id_q, rsp_id_d;

    assign stall = rsp_valid_q & ~rsp_ready;

    // Grants are suppressed while held in reset so gnt reads zero immediately.
    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_arbiter (
        .req     (req),
        .pointer (ptr_q),
        .enable  (~stall & rst_n),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    assign grant_any = |gnt;

    always_comb begin
        sum       = {1'b0, s1_x_q} + {1'b0, s1_y_q};
        alu_flags = '0;
        alu_flags[FLAG_SIGN]   = sum[WIDTH-1];
        alu_flags[FLAG_ZERO]   = (sum[WIDTH-1:0] == '0);
        alu_flags[FLAG_CARRY]  = sum[WIDTH];
        alu_flags[FLAG_PARITY] = ~^sum[WIDTH-1:0];
        alu_flags[FLAG_OVF]    = (s1_x_q[WIDTH-1] == s1_y_q[WIDTH-1]) &
                                 (sum[WIDTH-1] != s1_x_q[WIDTH-1]);
    end

    // Stall only exists with stage 2 full, so when unstalled both stages always advance.
    always_comb begin
        ptr_d       = ptr_q;
        s1_valid_d  = s1_valid_q;
        s1_x_d      = s1_x_q;
        s1_y_d      = s1_y_q;
        s1_id_d     = s1_id_q;
        rsp_valid_d = rsp_valid_q;
        z_d         = z_q;
        flags_d     = flags_q;
        rsp_id_d    = rsp_id_q;
        if (grant_any) begin
            ptr_d = gnt_idx;
        end
        if (!stall) begin
            s1_valid_d = grant_any;
            if (grant_any) begin
                s1_x_d  = x_in[int'(gnt_idx)*WIDTH +: WIDTH];
                s1_y_d  = y_in[int'(gnt_idx)*WIDTH +: WIDTH];
                s1_id_d = gnt_idx;
            end
            rsp_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                z_d      = sum[WIDTH-1:0];
                flags_d  = alu_flags;
                rsp_id_d = s1_id_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q       <= ID_W'(NUM_REQ - 1);
            s1_valid_q  <= 1'b0;
            s1_x_q      <= '0;
            s1_y_q      <= '0;
            s1_id_q     <= '0;
            rsp_valid_q <= 1'b0;
            z_q         <= '0;
            flags_q     <= '0;
            rsp_id_q    <= '0;
        end else begin
            ptr_q       <= ptr_d;
            s1_valid_q  <= s1_valid_d;
            s1_x_q      <= s1_x_d;
            s1_y_q      <= s1_y_d;
            s1_id_q     <= s1_id_d;
            rsp_valid_q <= rsp_valid_d;
            z_q         <= z_d;
            flags_q     <= flags_d;
            rsp_id_q    <= rsp_id_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign z         = z_q;
    assign flags     = flags_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter: flag vectors, round-robin order,
// backpressure and asynchronous reset.
module tb_alu_share_arbiter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req;
    logic [63:0] x_in;
    logic [63:0] y_in;
    logic [3:0]  gnt;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_id;
    logic [15:0] z;
    logic [4:0]  flags;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int          idx;
        logic [15:0] x;
        logic [15:0] y;
        logic [15:0] exp_z;
        logic [4:0]  exp_flags;   // {ovf, parity, carry, zero, sign}
    } vec_t;

    vec_t vecs[7];

    alu_share_arbiter #(
        .NUM_REQ (4),
        .WIDTH   (16),
        .ID_W    (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .x_in      (x_in),
        .y_in      (y_in),
        .gnt       (gnt),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .z         (z),
        .flags     (flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic apply_stimulus(input int idx, input logic [15:0] x, input logic [15:0] y);
        req = 4'(1 << idx);
        x_in[idx*16 +: 16] = x;
        y_in[idx*16 +: 16] = y;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req   = '0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic logic [15:0] rr_z(input int i);
        return 16'(256 * (i + 1) + (i + 1));
    endfunction

    initial begin
        logic [3:0] bp_gnt [11];
        logic       bp_rdy [11];
        logic       bp_req [11];
        logic       bp_val [11];
        int         bp_id  [11];
        logic [3:0] ws_gnt [3];

        vecs[0] = '{0, 16'h0003, 16'h0005, 16'h0008, 5'b00000};
        vecs[1] = '{1, 16'hFFFF, 16'h0001, 16'h0000, 5'b01110};
        vecs[2] = '{2, 16'h7FFF, 16'h0001, 16'h8000, 5'b10001};
        vecs[3] = '{3, 16'h8000, 16'h8000, 16'h0000, 5'b11110};
        vecs[4] = '{0, 16'h1234, 16'h4321, 16'h5555, 5'b01000};
        vecs[5] = '{1, 16'hFFFF, 16'hFFFF, 16'hFFFE, 5'b00101};
        vecs[6] = '{2, 16'h0000, 16'h0000, 16'h0000, 5'b01010};

        rst_n     = 1'b0;
        req       = '0;
        x_in      = '0;
        y_in      = '0;
        rsp_ready = 1'b1;
        #1;
        check_output("reset_gnt", 32'(gnt), 32'h0);
        check_output("reset_rsp_valid", 32'(rsp_valid), 32'h0);
        check_output("reset_rsp_id", 32'(rsp_id), 32'h0);
        check_output("reset_z", 32'(z), 32'h0);
        check_output("reset_flags", 32'(flags), 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Single operations, one at a time, through the full two-cycle latency.
        for (int v = 0; v < 7; v++) begin
            @(negedge clk);
            apply_stimulus(vecs[v].idx, vecs[v].x, vecs[v].y);
            #1;
            check_output($sformatf("vec%0d_gnt", v), 32'(gnt), 32'(1 << vecs[v].idx));
            check_output($sformatf("vec%0d_idle", v), 32'(rsp_valid), 32'h0);
            @(negedge clk);
            req = '0;
            @(negedge clk);
            #1;
            check_output($sformatf("vec%0d_valid", v), 32'(rsp_valid), 32'h1);
            check_output($sformatf("vec%0d_id", v), 32'(rsp_id), 32'(vecs[v].idx));
            check_output($sformatf("vec%0d_z", v), 32'(z), 32'(vecs[v].exp_z));
            check_output($sformatf("vec%0d_flags", v), 32'(flags), 32'(vecs[v].exp_flags));
        end

        // Round-robin fairness with all four requesting.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            x_in[i*16 +: 16] = 16'(256 * (i + 1));
            y_in[i*16 +: 16] = 16'(i + 1);
        end
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            req = (k < 8) ? 4'b1111 : 4'b0000;
            #1;
            check_output($sformatf("rr%0d_gnt", k), 32'(gnt), (k < 8) ? 32'(1 << (k % 4)) : 32'h0);
            if (k >= 2) begin
                check_output($sformatf("rr%0d_valid", k), 32'(rsp_valid), 32'h1);
                check_output($sformatf("rr%0d_id", k), 32'(rsp_id), 32'((k - 2) % 4));
                check_output($sformatf("rr%0d_z", k), 32'(z), 32'(rr_z((k - 2) % 4)));
            end
        end

        // Wrap and skip: last grant was requester 3.
        ws_gnt = '{4'b0001, 4'b0100, 4'b0001};
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            req = 4'b0101;
            #1;
            check_output($sformatf("ws%0d_gnt", k), 32'(gnt), 32'(ws_gnt[k]));
        end
        check_output("ws_rsp_id", 32'(rsp_id), 32'h0);
        req = '0;
        repeat (3) @(negedge clk);

        // Backpressure: two ops in flight, grants frozen, response held stable.
        do_reset();
        bp_rdy = '{1, 1, 0, 0, 0, 1, 1, 1, 1, 1, 1};
        bp_req = '{1, 1, 1, 1, 1, 1, 1, 1, 0, 0, 0};
        bp_gnt = '{4'b0001, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0100,
                   4'b1000, 4'b0001, 4'b0000, 4'b0000, 4'b0000};
        bp_val = '{0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 0};
        bp_id  = '{0, 0, 0, 0, 0, 0, 1, 2, 3, 0, 0};
        for (int k = 0; k < 11; k++) begin
            @(negedge clk);
            rsp_ready = bp_rdy[k];
            req       = bp_req[k] ? 4'b1111 : 4'b0000;
            #1;
            check_output($sformatf("bp%0d_gnt", k), 32'(gnt), 32'(bp_gnt[k]));
            check_output($sformatf("bp%0d_valid", k), 32'(rsp_valid), 32'(bp_val[k]));
            if (bp_val[k]) begin
                check_output($sformatf("bp%0d_id", k), 32'(rsp_id), 32'(bp_id[k]));
                check_output($sformatf("bp%0d_z", k), 32'(z), 32'(rr_z(bp_id[k])));
            end
        end

        // Asynchronous reset between edges while a response is pending.
        rsp_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            req = 4'b1111;
        end
        #1;
        check_output("ar_pre_valid", 32'(rsp_valid), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check_output("ar_valid", 32'(rsp_valid), 32'h0);
        check_output("ar_gnt", 32'(gnt), 32'h0);
        check_output("ar_z", 32'(z), 32'h0);
        check_output("ar_flags", 32'(flags), 32'h0);
        check_output("ar_id", 32'(rsp_id), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_output("ar_first_gnt", 32'(gnt), 32'h1);
        @(negedge clk);
        req = '0;
        #1;
        check_output("ar_t1_valid", 32'(rsp_valid), 32'h0);
        @(negedge clk);
        #1;
        check_output("ar_t2_valid", 32'(rsp_valid), 32'h1);
        check_output("ar_t2_id", 32'(rsp_id), 32'h0);
        check_output("ar_t2_z", 32'(z), 32'(rr_z(0)));
        repeat (2) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares one WIDTH-bit add/flag datapath among NUM_REQ requesters.
- Round-robin arbitration with a req/gnt handshake, plus a two-stage pipeline: operand register, then result/flag register.
- Returns z and the five status flags with the winning requester's ID on a valid/ready response port.
- Sits between issuing units (sequencers, address generators) and the shared adder.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- WIDTH, 16, operand/result width.
- ID_W, 2, width of requester ID; must equal ceil(log2(NUM_REQ)).

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- req  input  NUM_REQ  per-requester request; held with operands until granted.
- x_in  input  NUM_REQ*WIDTH  operand x, requester i at bits [i*WIDTH +: WIDTH].
- y_in  input  NUM_REQ*WIDTH  operand y, same packing.
- gnt  output  NUM_REQ  one-hot grant; operands captured at this clock edge.
- rsp_valid  output  1  response available.
- rsp_ready  input  1  consumer accepts response.
- rsp_id  output  ID_W  index of requester that owns the response.
- z  output  WIDTH  sum x+y, modulo 2^WIDTH, carry-in 0.
- flags  output  5  {overflow, parity, carry, zero, sign}.

Behaviour:
- Reset (rst_n low, asynchronous): gnt=0, rsp_valid=0, rsp_id=0, z=0, flags=0.
  - Both stage-valid bits cleared; round-robin pointer = NUM_REQ-1, so requester 0 wins first.
  - Reset mid-operation discards all in-flight operations; requesters must re-request.
- stall = rsp_valid & ~rsp_ready.
- gnt is combinational from req, pointer and stall.
  - When stall=1, gnt=0.
  - Otherwise, grant the first asserted req searching from pointer+1 upward with wrap-around.
  - On a grant, the pointer updates to the granted index at the clock edge.
- Handshake:
  - Requester i sees gnt[i]=1 in cycle T; its operands are captured at the end of T.
  - The requester may drop or change req/operands in T+1.
  - A req held through a non-granted cycle must not change operands.
- Stage 1 (end of T): captures x, y, ID; s1_valid=1.
- Stage 2 (end of T+1, if not stalled): registers z, flags, rsp_id; rsp_valid=1 during T+2.
- Latency: gnt to rsp_valid is 2 cycles. Throughput is 1 op/cycle when rsp_ready stays high.
- Stall:
  - Both stages hold their contents; no grants are issued.
  - rsp_* stay stable until accepted (rsp_valid & rsp_ready).
- Bubble collapse: stage 1 advances into an empty stage 2 even if the output is stalled; the pipeline never holds more than 2 operations.
- Arithmetic, with {carry, z} = x + y (WIDTH+1 bits):
  - sign = z[WIDTH-1].
  - zero = (z == 0).
  - parity = XNOR-reduce(z): 1 when z has an even number of ones.
  - overflow = (x[MSB] == y[MSB]) & (z[MSB] != x[MSB]), i.e. signed overflow.
- No req asserted: gnt=0 and the pointer is unchanged.
- A single requester holding req continuously is granted every unstalled cycle.

Decomposition:
- Shared package alu_ctrl_pkg:
  - Flag index constants FLAG_SIGN=0, FLAG_ZERO=1, FLAG_CARRY=2, FLAG_PARITY=3, FLAG_OVF=4.
  - FLAGS_W=5.
  - Default DATA_W=16.
- One sub-module, rr_arbiter (NUM_REQ): inputs req, pointer, enable; outputs one-hot gnt and binary index.
- The datapath and pipeline registers stay in the top module.

Test Plan:
- Reset then single op: req=4'b0001, x0=16'h0003, y0=16'h0005 -> gnt=0001 at T; at T+2 rsp_valid=1, rsp_id=0, z=16'h0008, flags: parity=0 (two ones -> odd? no: 0b1000 has one one -> parity=0), other flags 0.
- Flag corners:
  - 16'hFFFF + 16'h0001 -> z=0, zero=1, carry=1, parity=1, overflow=0.
  - 16'h7FFF + 16'h0001 -> z=16'h8000, sign=1, overflow=1, carry=0.
  - 16'h8000 + 16'h8000 -> z=0, carry=1, overflow=1, zero=1.
- Round-robin fairness: req=4'b1111 held 8 cycles -> gnt sequence 0001, 0010, 0100, 1000, 0001, ...; rsp_id sequence 0, 1, 2, 3, 0, ... two cycles later.
- Wrap and skip: last grant was requester 3, then req=4'b0101 -> gnt=0001, then 0100, then 0001.
- Backpressure: rsp_ready=0 for 3 cycles with req=4'b1111 -> at most 2 ops in flight, gnt=0 while stalled, rsp_* stable; after rsp_ready=1, responses delivered in grant order with no loss or duplication.
- Async reset mid-stream: assert rst_n=0 between clock edges while rsp_valid=1 -> outputs go to 0 immediately; after release, the first grant goes to requester 0.
